// File: rtl/uart_sys_pkg.sv
// rtl/uart_sys_pkg.sv - shared opcodes, operand addresses and decoder state type
package uart_sys_pkg;

    // Frame opcodes (first byte of every command frame)
    localparam logic [7:0] CMD_RF_WR   = 8'hAA;
    localparam logic [7:0] CMD_RF_RD   = 8'hBB;
    localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

    // Register-file locations that hold the ALU operands
    localparam int ADDR_OP_A = 0;
    localparam int ADDR_OP_B = 1;

    // ALU_FUN collides with the decoder port name, hence the ST_ prefix
    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_ADDR,
        ST_WR_DATA,
        ST_RD_ADDR,
        ST_RD_WAIT,
        ST_OP_A,
        ST_OP_B,
        ST_ALU_FUN,
        ST_ALU_WAIT,
        ST_SEND
    } dec_state_e;

endpackage

// File: rtl/uart_resp_sender.sv
// rtl/uart_resp_sender.sv - one- or two-byte response buffer with valid/ready handshake
// Ports: clk_i/rst_ni clock and async active-low reset; load_i/two_i/data_i load a
//        1- or 2-byte response (low byte first); tx_* byte stream; done_o pulses on the
//        handshake of the last byte.
module uart_resp_sender #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    load_i,
    input  logic                    two_i,
    input  logic [2*DATA_WIDTH-1:0] data_i,
    input  logic                    tx_ready_i,
    output logic [DATA_WIDTH-1:0]   tx_data_o,
    output logic                    tx_vld_o,
    output logic                    done_o
);

    logic [2*DATA_WIDTH-1:0] buf_q, buf_d;
    logic [1:0]              cnt_q, cnt_d;   // bytes still to send: 1 or 2
    logic                    vld_q, vld_d;
    logic                    xfer;

    assign xfer      = vld_q & tx_ready_i;
    assign done_o    = xfer & (cnt_q == 2'd1);
    assign tx_data_o = buf_q[DATA_WIDTH-1:0];
    assign tx_vld_o  = vld_q;

    always_comb begin
        buf_d = buf_q;
        cnt_d = cnt_q;
        vld_d = vld_q;
        if (load_i) begin
            buf_d = data_i;
            cnt_d = two_i ? 2'd2 : 2'd1;
            vld_d = 1'b1;
        end else if (xfer) begin
            // Shifting brings the high byte down so it is presented right after the low one
            buf_d = buf_q >> DATA_WIDTH;
            cnt_d = cnt_q - 2'd1;
            vld_d = (cnt_q == 2'd2);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            buf_q <= '0;
            cnt_q <= '0;
            vld_q <= 1'b0;
        end else begin
            buf_q <= buf_d;
            cnt_q <= cnt_d;
            vld_q <= vld_d;
        end
    end

endmodule

// File: rtl/uart_cmd_decoder.sv
// rtl/uart_cmd_decoder.sv - UART command frame decoder driving register file, ALU and responses
// Ports: CLK/RST clock and async active-low reset; RX_* received byte stream with error flag;
//        RF_* register-file strobes, address, data; ALU_EN/ALU_FUN/CLK_GATE_EN ALU control,
//        ALU_OUT/ALU_OUT_VLD result; TX_* response byte stream with valid/ready.
module uart_cmd_decoder
    import uart_sys_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int ALU_FUN_WIDTH = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [DATA_WIDTH-1:0]    RX_P_DATA,
    input  logic                     RX_D_VLD,
    input  logic                     RX_ERR,
    output logic                     RF_WrEn,
    output logic                     RF_RdEn,
    output logic [ADDR_WIDTH-1:0]    RF_Address,
    output logic [DATA_WIDTH-1:0]    RF_WrData,
    input  logic [DATA_WIDTH-1:0]    RF_RdData,
    input  logic                     RF_RdData_Valid,
    output logic                     ALU_EN,
    output logic [ALU_FUN_WIDTH-1:0] ALU_FUN,
    output logic                     CLK_GATE_EN,
    input  logic [2*DATA_WIDTH-1:0]  ALU_OUT,
    input  logic                     ALU_OUT_VLD,
    output logic [DATA_WIDTH-1:0]    TX_P_DATA,
    output logic                     TX_D_VLD,
    input  logic                     TX_READY
);

    dec_state_e               state_q, state_d;
    logic                     wren_q, wren_d;
    logic                     rden_q, rden_d;
    logic                     alu_en_q, alu_en_d;
    logic                     gate_q, gate_d;
    logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
    logic [DATA_WIDTH-1:0]    wrdata_q, wrdata_d;
    logic [ALU_FUN_WIDTH-1:0] fun_q, fun_d;

    logic                     snd_load, snd_two, snd_done;
    logic [2*DATA_WIDTH-1:0]  snd_data;
    logic                     rx_ok, rx_bad;

    assign rx_ok  = RX_D_VLD & ~RX_ERR;
    assign rx_bad = RX_D_VLD &  RX_ERR;

    always_comb begin
        state_d  = state_q;
        wren_d   = 1'b0;
        rden_d   = 1'b0;
        alu_en_d = 1'b0;
        gate_d   = gate_q;
        addr_d   = addr_q;
        wrdata_d = wrdata_q;
        fun_d    = fun_q;
        snd_load = 1'b0;
        snd_two  = 1'b0;
        snd_data = '0;
        case (state_q)
            ST_IDLE: begin
                if (rx_ok) begin
                    if (RX_P_DATA == DATA_WIDTH'(CMD_RF_WR))        state_d = ST_WR_ADDR;
                    else if (RX_P_DATA == DATA_WIDTH'(CMD_RF_RD))   state_d = ST_RD_ADDR;
                    else if (RX_P_DATA == DATA_WIDTH'(CMD_ALU_OP))  state_d = ST_OP_A;
                    else if (RX_P_DATA == DATA_WIDTH'(CMD_ALU_NOP)) state_d = ST_ALU_FUN;
                end
            end
            ST_WR_ADDR: begin
                if (rx_bad) state_d = ST_IDLE;
                else if (rx_ok) begin
                    addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
                    state_d = ST_WR_DATA;
                end
            end
            ST_WR_DATA: begin
                if (rx_bad) state_d = ST_IDLE;
                else if (rx_ok) begin
                    wren_d   = 1'b1;
                    wrdata_d = RX_P_DATA;
                    state_d  = ST_IDLE;
                end
            end
            ST_RD_ADDR: begin
                if (rx_bad) state_d = ST_IDLE;
                else if (rx_ok) begin
                    rden_d  = 1'b1;
                    addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
                    state_d = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                // RF_RdEn is high in the first RD_WAIT cycle, so a zero-latency
                // register file is captured here as well
                if (RF_RdData_Valid) begin
                    snd_load = 1'b1;
                    snd_data = {{DATA_WIDTH{1'b0}}, RF_RdData};
                    state_d  = ST_SEND;
                end
            end
            ST_OP_A, ST_OP_B: begin
                if (rx_bad) state_d = ST_IDLE;
                else if (rx_ok) begin
                    wren_d   = 1'b1;
                    wrdata_d = RX_P_DATA;
                    addr_d   = (state_q == ST_OP_A) ? ADDR_WIDTH'(ADDR_OP_A) : ADDR_WIDTH'(ADDR_OP_B);
                    state_d  = (state_q == ST_OP_A) ? ST_OP_B : ST_ALU_FUN;
                end
            end
            ST_ALU_FUN: begin
                if (rx_bad) state_d = ST_IDLE;
                else if (rx_ok) begin
                    alu_en_d = 1'b1;
                    gate_d   = 1'b1;
                    fun_d    = RX_P_DATA[ALU_FUN_WIDTH-1:0];
                    state_d  = ST_ALU_WAIT;
                end
            end
            ST_ALU_WAIT: begin
                if (ALU_OUT_VLD) begin
                    gate_d   = 1'b0;
                    snd_load = 1'b1;
                    snd_two  = 1'b1;
                    snd_data = ALU_OUT;
                    state_d  = ST_SEND;
                end
            end
            ST_SEND: begin
                if (snd_done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= ST_IDLE;
            wren_q   <= 1'b0;
            rden_q   <= 1'b0;
            alu_en_q <= 1'b0;
            gate_q   <= 1'b0;
            addr_q   <= '0;
            wrdata_q <= '0;
            fun_q    <= '0;
        end else begin
            state_q  <= state_d;
            wren_q   <= wren_d;
            rden_q   <= rden_d;
            alu_en_q <= alu_en_d;
            gate_q   <= gate_d;
            addr_q   <= addr_d;
            wrdata_q <= wrdata_d;
            fun_q    <= fun_d;
        end
    end

    assign RF_WrEn     = wren_q;
    assign RF_RdEn     = rden_q;
    assign RF_Address  = addr_q;
    assign RF_WrData   = wrdata_q;
    assign ALU_EN      = alu_en_q;
    assign ALU_FUN     = fun_q;
    assign CLK_GATE_EN = gate_q;

    uart_resp_sender #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_sender (
        .clk_i      (CLK),
        .rst_ni     (RST),
        .load_i     (snd_load),
        .two_i      (snd_two),
        .data_i     (snd_data),
        .tx_ready_i (TX_READY),
        .tx_data_o  (TX_P_DATA),
        .tx_vld_o   (TX_D_VLD),
        .done_o     (snd_done)
    );

endmodule
